player_ctl: RTL and testbench
=============================

Name: player_ctl

Overview:
- Per-frame motion controller that drives draw_player's xpos_player, ypos_player and state inputs.
- Samples movement buttons (already synchronous to clk, e.g. from the keyboard decoder) once per frame, at the vsync rising edge.
- Runs the horizontal direction FSM and the jump/gravity integrator, and clamps the player to the playfield.
- Sits between input decoding and draw_player in the 800x600 VGA pipeline.

Parameters:
- X_MIN, 0, leftmost legal xpos_player
- X_MAX, 760, rightmost legal xpos_player (800 minus 40 px sprite width)
- X_START, 380, xpos_player after reset
- GROUND_Y, 80, ypos_player when standing; larger values are lower on screen
- STEP_X, 4, horizontal pixels moved per frame
- JUMP_V0, 12, initial upward velocity in px/frame; 1..127
- GRAVITY, 1, velocity decrement per frame

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, synchronous, active-high
- vsync_in  in  1  vsync from the timing chain; the rising edge defines the frame tick
- btn_left  in  1  move-left request, level
- btn_right  in  1  move-right request, level
- btn_jump  in  1  jump request, level
- freeze  in  1  pause; frame ticks are ignored while high
- xpos_player  out  12  horizontal offset to draw_player
- ypos_player  out  12  vertical offset to draw_player
- state  out  State (state_pkg)  IDLE / RIGHT / LEFT, to draw_player
- airborne  out  1  high while a jump is in progress
- frame_tick  out  1  one-cycle pulse, the cycle after each accepted update

Behaviour:
- Tick detection
  - vsync_q is a register of vsync_in.
  - tick = vsync_in & ~vsync_q & ~freeze.
  - vsync_q resets to 1, so vsync held high through reset release gives no tick.
- Update timing
  - All position, state and velocity registers update only on the clk edge where tick=1.
  - Otherwise they hold.
  - frame_tick is registered: high exactly one cycle after that edge.
- Reset values
  - xpos_player=X_START, ypos_player=GROUND_Y, state=IDLE.
  - airborne=0, internal vel=0, frame_tick=0.
  - Reset mid-jump returns the player to ground on the next cycle.
- Horizontal FSM, evaluated on tick
  - btn_left & ~btn_right -> LEFT.
  - btn_right & ~btn_left -> RIGHT.
  - Both or neither -> IDLE.
  - The transition is legal from any state to any state.
  - The same tick moves x using the new state.
- X arithmetic
  - LEFT: x < X_MIN+STEP_X -> X_MIN, else x-STEP_X.
  - RIGHT: x > X_MAX-STEP_X -> X_MAX, else x+STEP_X.
  - IDLE: x holds.
  - Compare before subtracting so 12-bit underflow can never occur.
  - Horizontal motion continues while airborne.
- Vertical
  - vel is signed 8-bit; y is computed in 13-bit signed.
  - Jump start: on tick with ~airborne & btn_jump, set airborne=1 and vel=JUMP_V0; y is unchanged on this tick.
  - Airborne step: on tick with airborne, y_n = y - vel and vel <= vel - GRAVITY.
  - Ceiling: if y_n < 0, y=0 and vel=0.
  - Landing: if vel<0 and y_n >= GROUND_Y, y=GROUND_Y, vel=0, airborne=0.
  - A jump cannot restart on the landing tick. The earliest new start is the next tick with btn_jump held.
  - btn_jump while airborne is ignored.
- freeze
  - All outputs hold and the button states are discarded.
  - The first vsync rising edge after freeze falls resumes updates normally.

Optional Feature:
- Macro: PLAYER_CTL_WRAP_EN.
- Defined: horizontal wrap-around.
  - A LEFT step that would go below X_MIN gives x=X_MAX.
  - A RIGHT step that would exceed X_MAX gives x=X_MIN.
- Undefined: the clamping described above.
- Vertical behaviour is identical in both builds.

Test Plan:
- Reset with vsync_in=1, release, and hold vsync high for 5 cycles -> x=380, y=80, state=IDLE, airborne=0, no frame_tick.
- btn_right held for 3 vsync rising edges -> state=RIGHT, x = 384, 388, 392; frame_tick pulses once per edge, one cycle late.
- Movement and clamping, each without wrap:
  - x=2 with btn_left, 1 tick -> x=0, state=LEFT.
  - x=758 with btn_right -> x=760.
  - With WRAP_EN, x=2 with btn_left -> x=760.
- Single btn_jump pulse at tick 0 -> y=68 at tick 1, y=2 at ticks 12 and 13, landing with y=80 and airborne=0 at tick 25; btn_jump held at tick 25 does not restart, tick 26 does.
- Simultaneous events:
  - btn_left & btn_right together -> state=IDLE, x unchanged.
  - btn_right during a jump -> x advances 4 per tick while y follows the jump profile.
- Interrupts:
  - freeze=1 for 10 vsync edges mid-jump -> x, y, state and vel frozen; after release the profile continues from the frozen point.
  - rst mid-jump -> y=80, airborne=0 on the next cycle.

Source files
------------

// File: rtl/player_ctl_if.sv
// rtl/player_ctl_if.sv - state_pkg and the button/position interface between input decoding, player_ctl and draw_player
package state_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RIGHT = 2'd1,
        LEFT  = 2'd2
    } State;
endpackage

interface player_ctl_if;
    import state_pkg::*;

    logic        btn_left;
    logic        btn_right;
    logic        btn_jump;
    logic [11:0] xpos_player;
    logic [11:0] ypos_player;
    State        state;
    logic        airborne;
    logic        frame_tick;

    modport master (
        input  btn_left, btn_right, btn_jump,
        output xpos_player, ypos_player, state, airborne, frame_tick
    );

    modport slave (
        output btn_left, btn_right, btn_jump,
        input  xpos_player, ypos_player, state, airborne, frame_tick
    );
endinterface

// File: rtl/player_ctl.sv
// rtl/player_ctl.sv - per-frame player motion: direction FSM, jump/gravity integrator, playfield clamp
// Optional PLAYER_CTL_WRAP_EN: horizontal wrap-around at the playfield edges instead of clamping.
module player_ctl #(
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 760,
    parameter int X_START  = 380,
    parameter int GROUND_Y = 80,
    parameter int STEP_X   = 4,
    parameter int JUMP_V0  = 12,
    parameter int GRAVITY  = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         vsync_in,
    input  logic         freeze,
    player_ctl_if.master pl
);
    import state_pkg::*;

    localparam logic [11:0]        XMIN_W    = 12'(X_MIN);
    localparam logic [11:0]        XMAX_W    = 12'(X_MAX);
    localparam logic [11:0]        XSTART_W  = 12'(X_START);
    localparam logic [11:0]        GROUND_W  = 12'(GROUND_Y);
    localparam logic [11:0]        STEP_W    = 12'(STEP_X);
    localparam logic [11:0]        LEFT_LIM  = 12'(X_MIN + STEP_X);
    localparam logic [11:0]        RIGHT_LIM = 12'(X_MAX - STEP_X);
    localparam logic signed [7:0]  V0        = 8'(JUMP_V0);
    localparam logic signed [7:0]  GRAV      = 8'(GRAVITY);
    localparam logic signed [12:0] GROUND_S  = 13'(GROUND_Y);

    logic               vsync_q;
    logic               tick;
    State               st_q, st_n;
    logic [11:0]        x_q, x_n;
    logic [11:0]        y_q, y_n;
    logic signed [7:0]  vel_q, vel_n;
    logic               air_q, air_n;
    logic               ftick_q;
    logic signed [12:0] y_step;

    // A rising vsync edge is only a frame tick when not paused; edges seen while frozen are dropped.
    assign tick = vsync_in & ~vsync_q & ~freeze;

    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_q <= 1'b1;
            st_q    <= IDLE;
            x_q     <= XSTART_W;
            y_q     <= GROUND_W;
            vel_q   <= '0;
            air_q   <= 1'b0;
            ftick_q <= 1'b0;
        end else begin
            vsync_q <= vsync_in;
            st_q    <= st_n;
            x_q     <= x_n;
            y_q     <= y_n;
            vel_q   <= vel_n;
            air_q   <= air_n;
            ftick_q <= tick;
        end
    end

    always_comb begin
        st_n   = st_q;
        x_n    = x_q;
        y_n    = y_q;
        vel_n  = vel_q;
        air_n  = air_q;
        y_step = $signed({1'b0, y_q}) - $signed({{5{vel_q[7]}}, vel_q});

        if (tick) begin
            if (pl.btn_left && !pl.btn_right) begin
                st_n = LEFT;
            end else if (pl.btn_right && !pl.btn_left) begin
                st_n = RIGHT;
            end else begin
                st_n = IDLE;
            end

            // Limits are checked before stepping so the 12-bit position never wraps through zero.
            case (st_n)
                LEFT: begin
                    if (x_q < LEFT_LIM) begin
`ifdef PLAYER_CTL_WRAP_EN
                        x_n = XMAX_W;
`else
                        x_n = XMIN_W;
`endif
                    end else begin
                        x_n = x_q - STEP_W;
                    end
                end
                RIGHT: begin
                    if (x_q > RIGHT_LIM) begin
`ifdef PLAYER_CTL_WRAP_EN
                        x_n = XMIN_W;
`else
                        x_n = XMAX_W;
`endif
                    end else begin
                        x_n = x_q + STEP_W;
                    end
                end
                default: x_n = x_q;
            endcase

            // The airborne branch owns the landing tick, so a held jump cannot relaunch on it.
            if (air_q) begin
                if (y_step[12]) begin
                    y_n   = '0;
                    vel_n = '0;
                end else if (vel_q[7] && (y_step >= GROUND_S)) begin
                    y_n   = GROUND_W;
                    vel_n = '0;
                    air_n = 1'b0;
                end else begin
                    y_n   = y_step[11:0];
                    vel_n = vel_q - GRAV;
                end
            end else if (pl.btn_jump) begin
                air_n = 1'b1;
                vel_n = V0;
            end
        end
    end

    assign pl.xpos_player = x_q;
    assign pl.ypos_player = y_q;
    assign pl.state       = st_q;
    assign pl.airborne    = air_q;
    assign pl.frame_tick  = ftick_q;

endmodule

// File: tb/tb_player_ctl.sv
// tb/tb_player_ctl.sv - self-checking bench for player_ctl; define PLAYER_CTL_WRAP_EN for the wrap build
module tb_player_ctl;
    import state_pkg::*;

`ifdef PLAYER_CTL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic vsync_in;
    logic freeze;

    player_ctl_if bus ();

    player_ctl dut (
        .clk      (clk),
        .rst      (rst),
        .vsync_in (vsync_in),
        .freeze   (freeze),
        .pl       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: x as a clamped/wrapped integer, vertical motion as the number of
    // accepted ticks since the jump started (-1 when standing), y from the closed-form arc.
    int   m_x;
    int   m_jn;
    State m_st;

    localparam int LAND_N = 25;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int m_y();
        if (m_jn < 0) return 80;
        return 80 - 12 * m_jn + (m_jn * (m_jn - 1)) / 2;
    endfunction

    task automatic model_reset();
        m_x  = 380;
        m_jn = -1;
        m_st = IDLE;
    endtask

    task automatic model_tick(input bit l, input bit r, input bit j);
        if (l && !r) begin
            m_st = LEFT;
            if (m_x - 4 < 0) m_x = WRAP ? 760 : 0;
            else m_x = m_x - 4;
        end else if (r && !l) begin
            m_st = RIGHT;
            if (m_x + 4 > 760) m_x = WRAP ? 0 : 760;
            else m_x = m_x + 4;
        end else begin
            m_st = IDLE;
        end
        if (m_jn >= 0) begin
            m_jn++;
            if (m_jn == LAND_N) m_jn = -1;
        end else if (j) begin
            m_jn = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, " x"}, int'(bus.xpos_player), m_x);
        chk({tag, " y"}, int'(bus.ypos_player), m_y());
        chk({tag, " state"}, int'(bus.state), int'(m_st));
        chk({tag, " airborne"}, int'(bus.airborne), (m_jn >= 0) ? 1 : 0);
    endtask

    task automatic frame(input bit l, input bit r, input bit j, input bit fz, input string tag);
        @(negedge clk);
        vsync_in = 1'b0;
        freeze   = fz;
        @(negedge clk);
        vsync_in      = 1'b1;
        bus.btn_left  = l;
        bus.btn_right = r;
        bus.btn_jump  = j;
        @(negedge clk);
        if (!fz) model_tick(l, r, j);
        chk({tag, " frame_tick"}, int'(bus.frame_tick), fz ? 0 : 1);
        check_outputs(tag);
        @(negedge clk);
        chk({tag, " frame_tick_clear"}, int'(bus.frame_tick), 0);
        freeze = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        vsync_in = 1'b1;
        freeze   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit   l, r, j;
        int   ex, ey;
        State est;
        bit   eair;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1, 0, 384, 80, RIGHT, 0};
        vecs[1] = '{0, 1, 0, 388, 80, RIGHT, 0};
        vecs[2] = '{0, 1, 0, 392, 80, RIGHT, 0};
        vecs[3] = '{1, 1, 0, 392, 80, IDLE,  0};
        vecs[4] = '{1, 0, 0, 388, 80, LEFT,  0};
        vecs[5] = '{0, 0, 0, 388, 80, IDLE,  0};

        rst = 1'b1; vsync_in = 1'b1; freeze = 1'b0;
        bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_jump = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("reset no_tick", int'(bus.frame_tick), 0);
        end
        chk("reset x", int'(bus.xpos_player), 380);
        chk("reset y", int'(bus.ypos_player), 80);
        chk("reset state", int'(bus.state), int'(IDLE));
        chk("reset airborne", int'(bus.airborne), 0);

        for (int i = 0; i < 6; i++) begin
            frame(vecs[i].l, vecs[i].r, vecs[i].j, 1'b0, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d tbl_x", i), int'(bus.xpos_player), vecs[i].ex);
            chk($sformatf("vec%0d tbl_y", i), int'(bus.ypos_player), vecs[i].ey);
            chk($sformatf("vec%0d tbl_state", i), int'(bus.state), int'(vecs[i].est));
            chk($sformatf("vec%0d tbl_air", i), int'(bus.airborne), int'(vecs[i].eair));
        end

        // Jump with right held throughout; jump held again on the landing tick and after.
        frame(0, 1, 1, 0, "jump t0");
        chk("jump t0 air", int'(bus.airborne), 1);
        for (int n = 1; n <= 26; n++) begin
            frame(0, 1, (n == 1 || n >= 25), 0, $sformatf("jump t%0d", n));
            chk($sformatf("jump t%0d x", n), int'(bus.xpos_player), 388 + 4 * (n + 1));
            if (n == 1)  chk("jump t1 y", int'(bus.ypos_player), 68);
            if (n == 12) chk("jump t12 y", int'(bus.ypos_player), 2);
            if (n == 13) chk("jump t13 y", int'(bus.ypos_player), 2);
            if (n == 25) begin
                chk("land t25 y", int'(bus.ypos_player), 80);
                chk("land t25 air", int'(bus.airborne), 0);
            end
            if (n == 26) chk("restart t26 air", int'(bus.airborne), 1);
        end

        // Freeze mid-jump for 10 edges, then resume the arc.
        for (int n = 0; n < 5; n++) frame(0, 0, 0, 0, "pre_freeze");
        for (int n = 0; n < 10; n++) frame($urandom_range(0, 1), $urandom_range(0, 1), 1, 1, "frozen");
        frame(0, 0, 0, 0, "resume");
        chk("resume y", int'(bus.ypos_player), 80 - 12 * 6 + 15);
        while (m_jn >= 0) frame(0, 0, 0, 0, "post_freeze");

        // Reset mid-jump.
        frame(0, 0, 1, 0, "rjump0");
        for (int n = 0; n < 3; n++) frame(0, 0, 0, 0, "rjump");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid y", int'(bus.ypos_player), 80);
        chk("rst_mid air", int'(bus.airborne), 0);
        chk("rst_mid x", int'(bus.xpos_player), 380);
        rst = 1'b0;
        model_reset();

        // Playfield edges.
        do_reset();
        for (int n = 0; n < 95; n++) frame(1, 0, 0, 0, "to_left");
        chk("left edge x", int'(bus.xpos_player), 0);
        frame(1, 0, 0, 0, "past_left");
        chk("past_left x", int'(bus.xpos_player), WRAP ? 760 : 0);
        do_reset();
        for (int n = 0; n < 95; n++) frame(0, 1, 0, 0, "to_right");
        chk("right edge x", int'(bus.xpos_player), 760);
        frame(0, 1, 0, 0, "past_right");
        chk("past_right x", int'(bus.xpos_player), WRAP ? 0 : 760);

        // Randomized frames against the model.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            frame($urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 7) == 0), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
